// File: rtl/snn_input_loader.sv
// snn_input_loader: receives an image frame as UART bytes, unpacks each byte
// LSB-first into a 1-bit-wide input RAM, then starts the SNN core and holds
// off new frames until the core reports completion.
module snn_input_loader #(
  parameter int NUM_BYTES   = 98,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  input  logic       core_done,
  output logic       we,
  output logic [9:0] waddr,
  output logic       wdata,
  output logic       start,
  output logic       busy,
  output logic       err_ovr,
  output logic       err_to
);

  // Byte index is 7 bits so 8*k+i always fits the 10-bit address for up to
  // 128 bytes; the timeout counter only needs to reach TIMEOUT_CYC-1.
  localparam int CW = 7;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NUM_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_ONE    = TW'(1);
  localparam logic [TW-1:0] TO_ZERO   = TW'(0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_WAIT   = 3'd2,
    S_START  = 3'd3,
    S_CORE   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      byte_q, byte_d;
  logic [2:0]      bit_q, bit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   to_q, to_d;
  logic            err_ovr_q, err_ovr_d;
  logic            err_to_q, err_to_d;
  logic            we_q, we_d;
  logic [9:0]      waddr_q, waddr_d;
  logic            wdata_q, wdata_d;
  logic            start_q, start_d;
  logic            busy_q, busy_d;
  logic            to_expire_s;

  assign to_expire_s = (to_q == TO_LAST);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a byte arriving on the timeout cycle wins over the abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rx_rdy) state_d = S_UNPACK;
        else        state_d = S_IDLE;
      end
      S_UNPACK: begin
        if (bit_q == 3'd7) begin
          if (cnt_q == LAST_BYTE) state_d = S_START;
          else                    state_d = S_WAIT;
        end else begin
          state_d = S_UNPACK;
        end
      end
      S_WAIT: begin
        if (rx_rdy)           state_d = S_UNPACK;
        else if (to_expire_s) state_d = S_IDLE;
        else                  state_d = S_WAIT;
      end
      S_START: state_d = S_CORE;
      S_CORE: begin
        if (core_done) state_d = S_IDLE;
        else           state_d = S_CORE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: byte capture, bit/byte/timeout counters, sticky errors.
  always_comb begin
    byte_d    = byte_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    err_ovr_d = err_ovr_q;
    err_to_d  = err_to_q;
    case (state_q)
      S_IDLE: begin
        if (rx_rdy) begin
          byte_d    = rx_data;
          bit_d     = 3'd0;
          cnt_d     = {CW{1'b0}};
          to_d      = TO_ZERO;
          err_ovr_d = 1'b0;
          err_to_d  = 1'b0;
        end else begin
          byte_d = byte_q;
        end
      end
      S_UNPACK: begin
        // bit index wraps 7 -> 0, ready for the next byte
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          to_d = TO_ZERO;
          if (cnt_q != LAST_BYTE) cnt_d = cnt_q + 7'd1;
          else                    cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q;
        end
        if (rx_rdy) err_ovr_d = 1'b1;
        else        err_ovr_d = err_ovr_q;
      end
      S_WAIT: begin
        if (rx_rdy) begin
          byte_d = rx_data;
          to_d   = TO_ZERO;
        end else if (to_expire_s) begin
          err_to_d = 1'b1;
          cnt_d    = {CW{1'b0}};
          to_d     = TO_ZERO;
        end else begin
          to_d = to_q + TO_ONE;
        end
      end
      S_START, S_CORE: begin
        if (rx_rdy) err_ovr_d = 1'b1;
        else        err_ovr_d = err_ovr_q;
      end
      default: begin
        bit_d = 3'd0;
        cnt_d = {CW{1'b0}};
        to_d  = TO_ZERO;
      end
    endcase
  end

  // Output decode from next state so that the outputs leave flops aligned with state_q.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = 10'd0;
    wdata_d = 1'b0;
    start_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE);
    if (state_d == S_UNPACK) begin
      we_d    = 1'b1;
      waddr_d = {cnt_d, bit_d};
      wdata_d = byte_d[bit_d];
    end else begin
      we_d    = 1'b0;
      waddr_d = 10'd0;
      wdata_d = 1'b0;
    end
  end

  // Datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_q    <= 8'd0;
      bit_q     <= 3'd0;
      cnt_q     <= {CW{1'b0}};
      to_q      <= TO_ZERO;
      err_ovr_q <= 1'b0;
      err_to_q  <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= 10'd0;
      wdata_q   <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      byte_q    <= byte_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      err_ovr_q <= err_ovr_d;
      err_to_q  <= err_to_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
    end
  end

  assign we      = we_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign start   = start_q;
  assign busy    = busy_q;
  assign err_ovr = err_ovr_q;
  assign err_to  = err_to_q;

endmodule

// File: tb/tb_snn_input_loader.sv
// Bench for snn_input_loader: a per-cycle vector table on a short-timeout
// instance, plus hand-written sequences for full frame, timeout, race,
// core handshake and mid-frame reset.
module tb_snn_input_loader;

  logic       clk;
  logic       rst_n;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       core_done;

  // full-size instance (98 bytes, default timeout)
  logic       f_we, f_wdata, f_start, f_busy, f_eo, f_et;
  logic [9:0] f_waddr;
  // short instance (12 bytes, 50-cycle timeout)
  logic       t_we, t_wdata, t_start, t_busy, t_eo, t_et;
  logic [9:0] t_waddr;

  snn_input_loader #(.NUM_BYTES(98), .TIMEOUT_CYC(500000)) dut_f (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data), .core_done(core_done),
    .we(f_we), .waddr(f_waddr), .wdata(f_wdata), .start(f_start), .busy(f_busy),
    .err_ovr(f_eo), .err_to(f_et)
  );

  snn_input_loader #(.NUM_BYTES(12), .TIMEOUT_CYC(50)) dut_t (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data), .core_done(core_done),
    .we(t_we), .waddr(t_waddr), .wdata(t_wdata), .start(t_start), .busy(t_busy),
    .err_ovr(t_eo), .err_to(t_et)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int checks;
  int errors;
  int drv_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    rx_data = d;
    rx_rdy  = 1'b1;
    drv_cyc = cyc;
    tick();
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // full-frame write monitor on the full-size instance
  logic       mon_en;
  int         wcnt;
  int         starts;
  int         start_cyc;
  logic [7:0] a5;

  always @(negedge clk) begin
    if (mon_en) begin
      if (f_we) begin
        chk("frame_write", {22'd0, f_waddr, f_wdata}, {22'd0, wcnt[9:0], a5[wcnt[2:0]]});
        wcnt++;
      end
      if (f_start) begin
        starts++;
        start_cyc = cyc;
      end
    end
  end

  typedef struct {
    logic       rst_n;
    logic       rx;
    logic [7:0] d;
    logic       cd;
    logic       we;
    logic [9:0] a;
    logic       wd;
    logic       st;
    logic       bz;
    logic       eo;
    logic       et;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic x, input logic [7:0] d, input logic c,
                              input logic w, input logic [9:0] a, input logic wd,
                              input logic st, input logic bz, input logic eo, input logic et);
    vec_t v;
    v.rst_n = r; v.rx = x; v.d = d; v.cd = c;
    v.we = w; v.a = a; v.wd = wd; v.st = st; v.bz = bz; v.eo = eo; v.et = et;
    return v;
  endfunction

  vec_t tab[21];
  logic bad;

  initial begin
    checks = 0; errors = 0; cyc = 0; drv_cyc = 0;
    mon_en = 1'b0; wcnt = 0; starts = 0; start_cyc = 0; a5 = 8'hA5;
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; core_done = 1'b0;

    // rows: inputs for one cycle, then outputs of the short instance after that edge
    // 0x5A bits LSB first: 0,1,0,1,1,0,1,0 ; 0x81: 1,0,0,0,0,0,0,1
    tab[0]  = mk(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tab[1]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tab[2]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 10'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tab[3]  = mk(1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 10'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tab[4]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 10'd1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tab[5]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 10'd2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tab[6]  = mk(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 10'd3,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[7]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 10'd4,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[8]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 10'd5,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[9]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 10'd6,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[10] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 10'd7,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[11] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[12] = mk(1'b1, 1'b1, 8'h81, 1'b0, 1'b1, 10'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[13] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 10'd9,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[14] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 10'd10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[15] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 10'd11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[16] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 10'd12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[17] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 10'd13, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[18] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 10'd14, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[19] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 10'd15, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[20] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    #2;
    for (int i = 0; i < 21; i++) begin
      rst_n = tab[i].rst_n; rx_rdy = tab[i].rx; rx_data = tab[i].d; core_done = tab[i].cd;
      tick();
      chk($sformatf("vec%0d", i),
          {17'd0, t_we, t_waddr, t_wdata, t_start, t_busy, t_eo, t_et},
          {17'd0, tab[i].we, tab[i].a, tab[i].wd, tab[i].st, tab[i].bz, tab[i].eo, tab[i].et});
    end
    rx_rdy = 1'b0; core_done = 1'b0; rst_n = 1'b1;

    // full frame: 98 x 0xA5, 100-cycle gaps
    do_reset();
    wcnt = 0; starts = 0; mon_en = 1'b1;
    for (int b = 0; b < 98; b++) begin
      send(8'hA5);
      repeat (100) tick();
    end
    mon_en = 1'b0;
    chk("frame_writes", wcnt, 784);
    chk("frame_starts", starts, 1);
    chk("frame_start_lat", start_cyc - drv_cyc, 9);
    chk("frame_core_busy", {f_busy, f_we}, 2'b10);
    core_done = 1'b1; tick(); core_done = 1'b0;
    chk("frame_done_idle", {f_busy, f_start, f_eo, f_et}, 4'b0000);

    // reset in the middle of byte 5 at bit 4
    do_reset();
    for (int b = 0; b < 5; b++) begin
      send(8'h0F);
      repeat (9) tick();
    end
    send(8'hFF);
    repeat (4) tick();
    chk("rst_pre", {f_we, f_waddr, f_wdata}, {1'b1, 10'd44, 1'b1});
    rst_n = 1'b0; rx_rdy = 1'b1; rx_data = 8'hFF;
    tick();
    rst_n = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00;
    chk("rst_outputs", {f_we, f_waddr, f_wdata, f_start, f_busy, f_eo, f_et}, 16'd0);
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (f_we || f_start || f_busy) bad = 1'b1;
    end
    chk("rst_quiet", bad, 1'b0);
    send(8'h01);
    chk("rst_restart", {f_we, f_waddr, f_wdata}, {1'b1, 10'd0, 1'b1});

    // timeout: 10 bytes then silence on the short instance
    do_reset();
    for (int b = 0; b < 10; b++) begin
      send(8'h3C);
      if (b < 9) repeat (15) tick();
    end
    repeat (57) tick();
    chk("to_last_wait", {t_busy, t_et}, 2'b10);
    tick();
    chk("to_expired", {t_busy, t_et, t_we}, 3'b010);
    send(8'h01);
    chk("to_restart", {t_we, t_waddr, t_wdata, t_et}, {1'b1, 10'd0, 1'b1, 1'b0});

    // race: byte arrives on the final timeout cycle
    do_reset();
    send(8'h00);
    repeat (57) tick();
    rx_data = 8'h03; rx_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0; rx_data = 8'h00;
    chk("race_accept", {t_we, t_waddr, t_wdata, t_busy, t_et}, {1'b1, 10'd8, 1'b1, 1'b1, 1'b0});

    // core handshake on the short instance (12 bytes)
    do_reset();
    for (int b = 0; b < 12; b++) begin
      send(8'h55);
      if (b < 11) repeat (8) tick();
    end
    repeat (7) tick();
    chk("core_last_bit", {t_we, t_waddr, t_wdata}, {1'b1, 10'd95, 1'b0});
    tick();
    chk("core_start", {t_start, t_we, t_busy}, 3'b101);
    tick();
    chk("core_start_once", {t_start, t_busy}, 2'b01);
    rx_rdy = 1'b1; rx_data = 8'hFF;
    tick();
    rx_rdy = 1'b0; rx_data = 8'h00;
    chk("core_drop", {t_eo, t_we, t_busy}, 3'b101);
    repeat (5) tick();
    chk("core_wait", t_busy, 1'b1);
    core_done = 1'b1; tick(); core_done = 1'b0;
    chk("core_done", {t_busy, t_eo, t_start}, 3'b010);
    send(8'h80);
    chk("core_next", {t_we, t_waddr, t_wdata, t_eo}, {1'b1, 10'd0, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
